// File: rtl/control_router.sv
// control_router: debounced front-panel buttons and mode switch merged with UART host commands
// into per-mode one-cycle command strobes. Define CTRL_AUTOREPEAT_EN for hold-to-repeat.
module control_router #(
   parameter int unsigned NUM_BTN       = 4,
   parameter int unsigned NUM_MODE      = 2,
   parameter int unsigned DEB_CYCLES    = 1_000_000,
   parameter int unsigned LOCK_TIMEOUT  = 0,
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000,
   localparam int unsigned MODE_W = (NUM_MODE > 2) ? $clog2(NUM_MODE) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_BTN-1:0]          i_btn,
   input  logic                        i_sw_mode,
   input  logic [NUM_BTN-1:0]          i_pc_cmd,
   input  logic                        i_pc_mode,
   input  logic                        i_pc_mode_set,
   input  logic [MODE_W-1:0]           i_pc_mode_val,
   output logic [MODE_W-1:0]           o_mode,
   output logic [NUM_MODE*NUM_BTN-1:0] o_cmd,
   output logic [NUM_BTN-1:0]          o_btn_level,
   output logic                        o_pc_lock
);

   localparam int unsigned NUM_IN = NUM_BTN + 1;
   localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
   localparam int unsigned IDLE_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   // Switch lives in the top bit of the conditioned input vector.
   logic [NUM_IN-1:0]         sync1_q, sync2_q;
   logic [NUM_IN-1:0]         stable_q, stable_d;
   logic [DEB_W-1:0]          deb_cnt_q [NUM_IN];
   logic [DEB_W-1:0]          deb_cnt_d [NUM_IN];
   logic                      sw_ref_q;
   logic [NUM_BTN-1:0]        btn_prev_q;
   logic [MODE_W-1:0]         mode_q, mode_d, mode_inc_c;
   logic                      lock_q, lock_d;
   logic [IDLE_W-1:0]         idle_q, idle_d;
   logic [NUM_MODE*NUM_BTN-1:0] cmd_q, cmd_d;
   logic                      sw_edge_c, set_ok_c, host_act_c;
   logic [NUM_BTN-1:0]        press_c, rep_fire_c, evt_c;

   // Synchronisers run through reset so the switch level is valid when reset loads it.
   always_ff @(posedge clk) begin
      sync1_q <= {i_sw_mode, i_btn};
      sync2_q <= sync1_q;
   end

   // Debounce: flip the stable level once the input has differed for DEB_CYCLES cycles.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NUM_IN; i++) begin
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) stable_d[i] = sync2_q[i];
            else deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
         end
      end
   end

   assign sw_edge_c = stable_q[NUM_BTN] ^ sw_ref_q;
   assign press_c   = stable_q[NUM_BTN-1:0] & ~btn_prev_q;

`ifdef CTRL_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0]   rep_cnt_q [NUM_BTN];
   logic [REP_W-1:0]   rep_cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] rep_arm_q, rep_arm_d;

   // Count from the press cycle; first target is the delay, afterwards the period.
   always_comb begin
      rep_fire_c = '0;
      rep_arm_d  = '0;
      for (int b = 0; b < NUM_BTN; b++) begin
         rep_cnt_d[b] = '0;
         if (stable_q[b]) begin
            if (rep_cnt_q[b] == (rep_arm_q[b] ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY))) begin
               rep_fire_c[b] = 1'b1;
               rep_arm_d[b]  = 1'b1;
               rep_cnt_d[b]  = REP_W'(1);
            end else begin
               rep_arm_d[b]  = rep_arm_q[b];
               rep_cnt_d[b]  = rep_cnt_q[b] + REP_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_arm_q <= '0;
         for (int b = 0; b < NUM_BTN; b++) rep_cnt_q[b] <= '0;
      end else begin
         rep_arm_q <= rep_arm_d;
         for (int b = 0; b < NUM_BTN; b++) rep_cnt_q[b] <= rep_cnt_d[b];
      end
   end
`else
   logic unused_rep_c;
   assign unused_rep_c = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
   assign rep_fire_c   = '0;
`endif

   assign evt_c = press_c | i_pc_cmd | rep_fire_c;

   // Mode, host lock and command decode; commands use the mode held before this edge.
   always_comb begin
      set_ok_c   = i_pc_mode_set && (32'(i_pc_mode_val) < NUM_MODE);
      host_act_c = set_ok_c | i_pc_mode | (|i_pc_cmd);
      mode_inc_c = (mode_q == MODE_W'(NUM_MODE - 1)) ? '0 : mode_q + MODE_W'(1);
      mode_d     = mode_q;
      lock_d     = lock_q;
      idle_d     = idle_q;
      cmd_d      = '0;

      if (set_ok_c) begin
         mode_d = i_pc_mode_val;
         lock_d = 1'b1;
      end else if (i_pc_mode) begin
         mode_d = mode_inc_c;
         lock_d = 1'b1;
      end else if (sw_edge_c && !lock_q) begin
         mode_d = mode_inc_c;
      end

      if (host_act_c) idle_d = '0;
      else if (idle_q != IDLE_W'(LOCK_TIMEOUT)) idle_d = idle_q + IDLE_W'(1);

      if ((LOCK_TIMEOUT > 0) && !host_act_c && (idle_q == IDLE_W'(LOCK_TIMEOUT))) lock_d = 1'b0;

      for (int m = 0; m < NUM_MODE; m++) begin
         if (mode_q == MODE_W'(m)) cmd_d[m*NUM_BTN +: NUM_BTN] = evt_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stable_q   <= {sync2_q[NUM_BTN], {NUM_BTN{1'b0}}};
         sw_ref_q   <= sync2_q[NUM_BTN];
         btn_prev_q <= '0;
         mode_q     <= '0;
         lock_q     <= 1'b0;
         idle_q     <= '0;
         cmd_q      <= '0;
         for (int i = 0; i < NUM_IN; i++) deb_cnt_q[i] <= '0;
      end else begin
         stable_q   <= stable_d;
         sw_ref_q   <= stable_q[NUM_BTN];
         btn_prev_q <= stable_q[NUM_BTN-1:0];
         mode_q     <= mode_d;
         lock_q     <= lock_d;
         idle_q     <= idle_d;
         cmd_q      <= cmd_d;
         for (int i = 0; i < NUM_IN; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      end
   end

   assign o_mode      = mode_q;
   assign o_cmd       = cmd_q;
   assign o_btn_level = stable_q[NUM_BTN-1:0];
   assign o_pc_lock   = lock_q;

endmodule

// File: tb/tb_control_router.sv
// Self-checking bench for control_router: expected command strobes are queued with their
// cycle of arrival and matched by a negedge monitor; mode/lock/level checked inline.
module tb_control_router;

   localparam int unsigned NB = 4;
   localparam int unsigned NM = 3;
   localparam int unsigned MW = 2;
   localparam int unsigned CW = NB * NM;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] i_btn = '0;
   logic          i_sw_mode = 1'b0;
   logic [NB-1:0] i_pc_cmd = '0;
   logic          i_pc_mode = 1'b0;
   logic          i_pc_mode_set = 1'b0;
   logic [MW-1:0] i_pc_mode_val = '0;
   logic [MW-1:0] o_mode;
   logic [CW-1:0] o_cmd;
   logic [NB-1:0] o_btn_level;
   logic          o_pc_lock;

   control_router #(
      .NUM_BTN(NB), .NUM_MODE(NM), .DEB_CYCLES(8), .LOCK_TIMEOUT(20),
      .REPEAT_DELAY(30), .REPEAT_PERIOD(10)
   ) dut (
      .clk(clk), .rst(rst), .i_btn(i_btn), .i_sw_mode(i_sw_mode),
      .i_pc_cmd(i_pc_cmd), .i_pc_mode(i_pc_mode), .i_pc_mode_set(i_pc_mode_set),
      .i_pc_mode_val(i_pc_mode_val), .o_mode(o_mode), .o_cmd(o_cmd),
      .o_btn_level(o_btn_level), .o_pc_lock(o_pc_lock)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            at;
      logic [CW-1:0] cmd;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_err = 0;

   // Scoreboard monitor for command strobes.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         n_cmp++;
         n_err++;
         $display("FAIL cmd_missing: got nothing at cycle %0d, required cmd %h", exp_q[0].at, exp_q[0].cmd);
         void'(exp_q.pop_front());
      end
      if (o_cmd !== '0) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL cmd_unexpected: got %h at cycle %0d, required none", o_cmd, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.at != cyc || e.cmd !== o_cmd) begin
               n_err++;
               $display("FAIL cmd_pulse: got %h at cycle %0d, required %h at cycle %0d", o_cmd, cyc, e.cmd, e.at);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic to_cyc(input int c);
      while (cyc < c) tick(1);
   endtask

   function automatic logic [CW-1:0] bitv(input int b);
      logic [CW-1:0] v;
      v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   task automatic push(input int at, input logic [CW-1:0] cmd);
      exp_t x;
      x.at  = at;
      x.cmd = cmd;
      exp_q.push_back(x);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(4);
      n_cmp += 4;
      if (o_mode !== '0)      begin n_err++; $display("FAIL reset_mode: got %0d, required 0", o_mode); end
      if (o_cmd !== '0)       begin n_err++; $display("FAIL reset_cmd: got %h, required 0", o_cmd); end
      if (o_btn_level !== '0) begin n_err++; $display("FAIL reset_level: got %b, required 0", o_btn_level); end
      if (o_pc_lock !== 1'b0) begin n_err++; $display("FAIL reset_lock: got %b, required 0", o_pc_lock); end
      rst = 1'b0;
      tick(3);
   endtask

   task automatic test_host_cmd();
      int last;
      i_pc_mode_set = 1'b1; i_pc_mode_val = 2'd2;
      tick(1);
      i_pc_mode_set = 1'b0;
      n_cmp += 2;
      if (o_mode !== 2'd2)    begin n_err++; $display("FAIL host_set_mode: got %0d, required 2", o_mode); end
      if (o_pc_lock !== 1'b1) begin n_err++; $display("FAIL host_set_lock: got %b, required 1", o_pc_lock); end
      tick(2);
      push(cyc + 1, bitv(10));
      i_pc_cmd = 4'b0100;
      tick(1);
      i_pc_cmd = '0;
      n_cmp++;
      if (o_cmd !== bitv(10)) begin n_err++; $display("FAIL host_cmd_bit10: got %h, required %h", o_cmd, bitv(10)); end
      tick(1);
      n_cmp++;
      if (o_cmd !== '0) begin n_err++; $display("FAIL host_cmd_width: got %h, required 0", o_cmd); end
      tick(2);
      last = cyc;
      push(cyc + 1, 12'b1011_0000_0000);
      i_pc_cmd = 4'b1011;
      tick(1);
      i_pc_cmd = '0;
      to_cyc(last + 21);
      n_cmp++;
      if (o_pc_lock !== 1'b1) begin n_err++; $display("FAIL lock_hold: got %b, required 1", o_pc_lock); end
      to_cyc(last + 22);
      n_cmp++;
      if (o_pc_lock !== 1'b0) begin n_err++; $display("FAIL lock_release: got %b, required 0", o_pc_lock); end
   endtask

   task automatic test_mode_lock();
      int m, p;
      m = cyc;
      i_pc_mode_set = 1'b1; i_pc_mode_val = 2'd1;
      tick(1);
      i_pc_mode_set = 1'b0;
      n_cmp += 2;
      if (o_mode !== 2'd1)    begin n_err++; $display("FAIL ml_set_mode: got %0d, required 1", o_mode); end
      if (o_pc_lock !== 1'b1) begin n_err++; $display("FAIL ml_set_lock: got %b, required 1", o_pc_lock); end
      i_sw_mode = 1'b1;
      to_cyc(m + 16);
      n_cmp++;
      if (o_mode !== 2'd1)    begin n_err++; $display("FAIL ml_sw_locked: got %0d, required 1", o_mode); end
      to_cyc(m + 21);
      n_cmp++;
      if (o_pc_lock !== 1'b1) begin n_err++; $display("FAIL ml_lock_hold: got %b, required 1", o_pc_lock); end
      to_cyc(m + 22);
      n_cmp++;
      if (o_pc_lock !== 1'b0) begin n_err++; $display("FAIL ml_lock_release: got %b, required 0", o_pc_lock); end
      p = cyc;
      i_sw_mode = 1'b0;
      to_cyc(p + 10);
      n_cmp++;
      if (o_mode !== 2'd1)    begin n_err++; $display("FAIL ml_sw_early: got %0d, required 1", o_mode); end
      to_cyc(p + 11);
      n_cmp++;
      if (o_mode !== 2'd2)    begin n_err++; $display("FAIL ml_sw_step: got %0d, required 2", o_mode); end
      p = cyc;
      i_sw_mode = 1'b1;
      to_cyc(p + 11);
      n_cmp++;
      if (o_mode !== 2'd0)    begin n_err++; $display("FAIL ml_sw_wrap: got %0d, required 0", o_mode); end
      tick(3);
   endtask

   task automatic test_debounce();
      int n;
      for (int k = 0; k < 6; k++) begin
         i_btn[1] = (k % 2 == 0);
         tick(3);
      end
      n = cyc;
      i_btn[1] = 1'b1;
      push(n + 11, bitv(1));
      to_cyc(n + 10);
      n_cmp++;
      if (o_btn_level !== 4'b0010) begin n_err++; $display("FAIL deb_level: got %b, required 0010", o_btn_level); end
      to_cyc(n + 20);
      i_btn[1] = 1'b0;
      to_cyc(n + 40);
      n_cmp += 2;
      if (o_btn_level !== '0)  begin n_err++; $display("FAIL deb_release: got %b, required 0", o_btn_level); end
      if (exp_q.size() != 0)   begin n_err++; $display("FAIL deb_pending: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_simultaneous();
      int p, b;
      i_pc_mode = 1'b1;
      tick(1);
      i_pc_mode = 1'b0;
      n_cmp++;
      if (o_mode !== 2'd1) begin n_err++; $display("FAIL sim_adv: got %0d, required 1", o_mode); end
      p = cyc;
      i_sw_mode = 1'b0;
      to_cyc(p + 10);
      i_pc_mode_set = 1'b1; i_pc_mode_val = 2'd0; i_pc_mode = 1'b1; i_pc_cmd = 4'b0001;
      push(cyc + 1, bitv(4));
      tick(1);
      i_pc_mode_set = 1'b0; i_pc_mode = 1'b0; i_pc_cmd = '0;
      n_cmp++;
      if (o_mode !== 2'd0) begin n_err++; $display("FAIL sim_mode: got %0d, required 0", o_mode); end
      tick(5);
      n_cmp++;
      if (o_mode !== 2'd0) begin n_err++; $display("FAIL sim_no_late_step: got %0d, required 0", o_mode); end
      b = cyc;
      i_pc_mode = 1'b1;
      tick(1);
      i_pc_mode = 1'b0;
      to_cyc(b + 5);
      i_pc_mode_set = 1'b1; i_pc_mode_val = 2'd3;
      tick(1);
      i_pc_mode_set = 1'b0; i_pc_mode_val = 2'd0;
      n_cmp++;
      if (o_mode !== 2'd1) begin n_err++; $display("FAIL sim_invalid_set: got %0d, required 1", o_mode); end
      to_cyc(b + 22);
      n_cmp++;
      if (o_pc_lock !== 1'b0) begin n_err++; $display("FAIL sim_invalid_no_lock: got %b, required 0", o_pc_lock); end
   endtask

   task automatic test_autorepeat();
      int n;
      n = cyc;
      i_btn[3] = 1'b1;
      push(n + 11, bitv(7));
`ifdef CTRL_AUTOREPEAT_EN
      push(n + 41, bitv(7));
      push(n + 51, bitv(11));
      push(n + 61, bitv(11));
`endif
      to_cyc(n + 11);
      n_cmp++;
      if (o_btn_level !== 4'b1000) begin n_err++; $display("FAIL rep_level: got %b, required 1000", o_btn_level); end
      to_cyc(n + 45);
      i_pc_mode = 1'b1;
      tick(1);
      i_pc_mode = 1'b0;
      n_cmp++;
      if (o_mode !== 2'd2) begin n_err++; $display("FAIL rep_mode: got %0d, required 2", o_mode); end
      to_cyc(n + 55);
      i_btn[3] = 1'b0;
      to_cyc(n + 85);
      n_cmp++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL rep_pending: got %0d left, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_hold();
      int n;
      n = cyc;
      i_btn[0] = 1'b1;
      push(n + 11, bitv(8));
      to_cyc(n + 25);
      rst = 1'b1; i_sw_mode = 1'b1; i_btn = '0;
      tick(1);
      n_cmp += 4;
      if (o_mode !== '0)      begin n_err++; $display("FAIL rmh_mode: got %0d, required 0", o_mode); end
      if (o_cmd !== '0)       begin n_err++; $display("FAIL rmh_cmd: got %h, required 0", o_cmd); end
      if (o_btn_level !== '0) begin n_err++; $display("FAIL rmh_level: got %b, required 0", o_btn_level); end
      if (o_pc_lock !== 1'b0) begin n_err++; $display("FAIL rmh_lock: got %b, required 0", o_pc_lock); end
      tick(3);
      rst = 1'b0;
      tick(20);
      n_cmp += 2;
      if (o_mode !== '0)     begin n_err++; $display("FAIL rmh_no_step: got %0d, required 0", o_mode); end
      if (exp_q.size() != 0) begin n_err++; $display("FAIL rmh_pending: got %0d left, required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_host_cmd();
      test_mode_lock();
      test_debounce();
      test_simultaneous();
      test_autorepeat();
      test_reset_mid_hold();
      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule
